// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: 8-digit seven-segment scanner with tear-free frame commit, PWM brightness and blanking
module sevenseg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int DIGIT_TICKS = 3125,
  parameter int BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [31:0] i_wr_data,
  input  logic [7:0]  i_wr_en,
  input  logic [7:0]  i_wr_dp,
  input  logic [3:0]  i_brightness,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_start
);
  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int PW = TW + 5;
  localparam int DW = $clog2(N_DIGITS);
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [TW-1:0] tick;
  logic [DW-1:0] digit;
  logic          pend_full;
  logic [31:0]   pend_data, act_data;
  logic [7:0]    pend_en, pend_dp, act_en, act_dp;
  logic [3:0]    act_bright;
  logic          tick_last, fb, accept, on;
  logic [3:0]    nib;
  logic [PW-1:0] tick_w, lit_lim;
  // Slot/frame boundary detection, handshake and per-digit drive condition
  always_comb begin
    tick_last = tick == TW'(DIGIT_TICKS - 1);
    fb        = tick_last && digit == DW'(N_DIGITS - 1);
    accept    = i_wr_valid && !pend_full;
    tick_w    = PW'(tick);
    lit_lim   = PW'({1'b0, act_bright} + 5'd1) * PW'(DIGIT_TICKS);
    on        = act_en[digit] && tick_w >= PW'(BLANK_TICKS) && (tick_w << 4) < lit_lim;
    nib       = act_data[{digit, 2'b00} +: 4];
  end
  assign o_wr_ready = !pend_full;
  // Slot tick and digit index counters
  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= '0;
      digit <= '0;
    end else begin
      tick  <= tick_last ? '0 : tick + 1'b1;
      digit <= !tick_last ? digit : digit == DW'(N_DIGITS - 1) ? '0 : digit + 1'b1;
    end
  end
  // Pending buffer fill and commit to active only at the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_en    <= '0;
      pend_dp    <= '0;
      act_data   <= '0;
      act_en     <= '0;
      act_dp     <= '0;
      act_bright <= '0;
    end else begin
      if (fb) begin
        act_bright <= i_brightness;
        if (pend_full) begin
          act_data <= pend_data;
          act_en   <= pend_en;
          act_dp   <= pend_dp;
        end
      end
      if (accept) begin
        pend_data <= i_wr_data;
        pend_en   <= i_wr_en;
        pend_dp   <= i_wr_dp;
      end
      pend_full <= accept || (pend_full && !fb);
    end
  end
  // Registered display outputs, one cycle behind the counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      o_an          <= 8'hFF;
      o_seg         <= 7'h7F;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_an          <= on ? ~(8'd1 << digit) : 8'hFF;
      o_seg         <= on ? SEG[nib] : 7'h7F;
      o_dp          <= ~(act_dp[digit] & on);
      o_frame_start <= fb;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed and random checks against a cycle-position reference model
module tb_sevenseg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_en = '0;
  logic [7:0]  wr_dp = '0;
  logic [3:0]  brightness = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  int tests = 0;
  int fails = 0;
  int n = 0;
  bit p_full = 0;
  logic [31:0] p_data = '0, a_data = '0;
  logic [7:0]  p_en = '0, p_dp = '0, a_en = '0, a_dp = '0;
  int a_b = 0;
  bit last_acc;

  sevenseg_scan_ctrl #(.N_DIGITS(8), .DIGIT_TICKS(8), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_data(wr_data), .i_wr_en(wr_en), .i_wr_dp(wr_dp), .i_brightness(brightness),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001; 4'h1: return 7'b1001111; 4'h2: return 7'b0010010; 4'h3: return 7'b0000110;
      4'h4: return 7'b1001100; 4'h5: return 7'b0100100; 4'h6: return 7'b0100000; 4'h7: return 7'b0001111;
      4'h8: return 7'b0000000; 4'h9: return 7'b0000100; 4'hA: return 7'b0001000; 4'hB: return 7'b1100000;
      4'hC: return 7'b0110001; 4'hD: return 7'b1000010; 4'hE: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle pos %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    int t, d;
    bit fb, on, acc;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    t = n % 8;
    d = (n / 8) % 8;
    fb = (n % 64) == 63;
    on = a_en[d] && t >= 1 && t * 16 < (a_b + 1) * 8;
    acc = !rst && wr_valid && !p_full;
    e_an = on ? ~(8'd1 << d) : 8'hFF;
    e_seg = on ? decode(a_data[d*4 +: 4]) : 7'h7F;
    e_dp = !(a_dp[d] && on);
    e_fs = fb;
    @(posedge clk);
    #1;
    if (rst) begin
      n = 0; p_full = 0; p_data = '0; p_en = '0; p_dp = '0;
      a_data = '0; a_en = '0; a_dp = '0; a_b = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      if (fb) begin
        a_b = brightness;
        if (p_full) begin
          a_data = p_data; a_en = p_en; a_dp = p_dp; p_full = 0;
        end
      end
      if (acc) begin
        p_data = wr_data; p_en = wr_en; p_dp = wr_dp; p_full = 1;
      end
      n++;
    end
    last_acc = acc;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_start", frame_start, e_fs);
    chk("wr_ready", wr_ready, !p_full);
    chk("one_anode", $countones(~an) <= 1, 1);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic write(input logic [31:0] data, input logic [7:0] en, input logic [7:0] dpv);
    bit got;
    got = 0;
    wr_data = data; wr_en = en; wr_dp = dpv; wr_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = last_acc;
    end
    wr_valid = 1'b0;
    chk("wr_accept", got, 1);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    chk("reset_an", an, 8'hFF);
    chk("reset_ready", wr_ready, 1);
    rst = 1'b0;
    run(200);
    brightness = 4'd15;
    write(32'h76543210, 8'hFF, 8'h01);
    run(140);
    brightness = 4'd3;
    run(130);
    brightness = 4'd0;
    run(130);
    brightness = 4'd15;
    write(32'h01234567, 8'b0000_0100, 8'h04);
    run(130);
    while ((n % 64) != 63 || p_full) step();
    wr_data = 32'hAAAAAAAA; wr_en = 8'hFF; wr_dp = 8'h00; wr_valid = 1'b1;
    step();
    chk("acc_on_fb", last_acc, 1);
    write(32'hBBBBBBBB, 8'hFF, 8'hFF);
    run(200);
    write($urandom, 8'hFF, 8'h20);
    run(70);
    while ((n % 64) != 43) step();
    chk("t6_lit", an, 8'hDF);
    rst = 1'b1;
    step();
    chk("t6_rst_an", an, 8'hFF);
    chk("t6_rst_ready", wr_ready, 1);
    rst = 1'b0;
    run(100);
    for (int r = 0; r < 30; r++) begin
      wr_data = $urandom; wr_en = 8'($urandom); wr_dp = 8'($urandom);
      brightness = 4'($urandom);
      for (int c = 0; c < 40; c++) begin
        wr_valid = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 79) == 0);
        step();
      end
      rst = 1'b0;
      wr_valid = 1'b0;
    end
    run(70);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
